// File: rtl/wb_pkg.sv
// Shared types and widths for the Wishbone-style master and its helpers.
package wb_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_mst_state_t;
endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus wait counter: cleared on transaction start, saturates at limit.
module wb_timeout_ctr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/wb_master.sv
// Single-outstanding bus master: command handshake -> strobed bus cycle
// with ack/timeout -> one-cycle response pulse. All outputs registered.
module wb_master
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              strb,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ack
);
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  wb_mst_state_t     state_q;
  logic              cmd_ready_q, strb_q, we_q, rsp_valid_q, rsp_err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rsp_rdata_q;
  logic              hs, expired;

  assign hs = (state_q == IDLE) && cmd_valid && cmd_ready_q;

  wb_timeout_ctr #(.W(CW)) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr     (hs),
    .en      ((state_q == BUS) && !ack),
    .limit   (CW'(TIMEOUT_CYC - 1)),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      strb_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (hs) begin
          we_q        <= cmd_we;
          addr_q      <= cmd_addr;
          wdata_q     <= cmd_wdata;
          strb_q      <= 1'b1;
          cmd_ready_q <= 1'b0;
          state_q     <= BUS;
        end
        // ack wins over a coincident timeout
        BUS: if (ack) begin
          rsp_rdata_q <= we_q ? '0 : rdata;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          strb_q      <= 1'b0;
          state_q     <= RESP;
        end else if (expired) begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b1;
          rsp_valid_q <= 1'b1;
          strb_q      <= 1'b0;
          state_q     <= RESP;
        end
        RESP: begin
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          cmd_ready_q <= 1'b1;
          strb_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign strb      = strb_q;
  assign we        = we_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
endmodule
